xfm_rec_pix_out: RTL and testbench
==================================

// Module: xfm_rec_pix_out
// PURPOSE
// - Downstream neighbour of the transform-reconstruction stage.
// - Captures one reconstructed 8x2 block: 16 samples each of c0 (Y), c1 (Co) and c2 (Cg).
// - Buffers up to DEPTH blocks, applies inverse YCoCg-R colour conversion with clipping, and emits pixels one 8-pixel row per beat.
// - Output feeds the reconstructed-pixel / neighbour line store over a valid/ready handshake.
// PARAMETERS
// - BPC    8  pixel bit depth; c0 is BPC bits unsigned; c1/c2 are BPC+1 bits signed two's complement.
// - DEPTH  2  block buffer entries, 1..4.
// PORTS
// - clk        in   1            clock
// - rstn       in   1            asynchronous active-low reset
// - rec_vld    in   1            input block valid
// - rec_rdy    out  1            input ready (registered)
// - rec_c0     in   16*BPC       Y samples; sample i at [i*BPC +: BPC]; i = row*8 + col
// - rec_c1     in   16*(BPC+1)   Co samples, same packing, signed
// - rec_c2     in   16*(BPC+1)   Cg samples, same packing, signed
// - out_vld    out  1            output row valid
// - out_rdy    in   1            downstream ready
// - out_r      out  8*BPC        row pixels; col j at [j*BPC +: BPC]
// - out_g      out  8*BPC        same packing
// - out_b      out  8*BPC        same packing
// - out_row    out  1            0 = top row, 1 = bottom row of the block
// - out_last   out  1            high on the row-1 beat (end of block)
// BEHAVIOUR
// - Reset: one clock, clk; reset is asynchronous and active-low on rstn.
//   - All outputs, wr_ptr, rd_ptr, count and row_sel clear to 0.
//   - rec_rdy = 0 during reset; rises to 1 on the first clk edge after rstn deasserts.
//   - Reset mid-block discards all buffered and in-flight data immediately.
// - Input side:
//   - Push on (rec_vld && rec_rdy): store c0/c1/c2 at wr_ptr; wr_ptr wraps at DEPTH.
//   - rec_rdy is registered: next value is (count_next < DEPTH). There is no combinational path from out_rdy to rec_rdy.
//   - When full and popping in the same cycle, the push is refused that cycle; rec_rdy returns the cycle after.
// - Output register stage:
//   - Loads when (!out_vld || out_rdy) && count != 0.
//   - Source is the head entry, row row_sel.
//   - A load sets out_row = row_sel and out_last = row_sel; row_sel then toggles.
//   - Loading row 1 pops the head: rd_ptr++ (wrap), count--.
//   - If no load and out_rdy && out_vld, then out_vld goes to 0.
//   - out_* hold stable while (out_vld && !out_rdy).
// - Latency: a block accepted at edge N shows row 0 after edge N+1 and row 1 after edge N+2 if out_rdy = 1.
// - Throughput: 1 block per 2 cycles; out_vld stays continuous under continuous supply.
// - Simultaneous push and pop: count unchanged; both pointers advance.
// - CSC arithmetic (signed, BPC+3 bits, arithmetic shifts):
//   - t = Y - (Cg>>>1)
//   - G = Cg + t
//   - B = t - (Co>>>1)
//   - R = B + Co
//   - Each of R/G/B is clipped to [0, 2^BPC - 1].
// - FSM: implicit in row_sel.
//   - EMPTY (count = 0, row_sel = 0)
//   - ROW0 -> ROW1 on a load
//   - ROW1 -> ROW0 on a load, with the head popped
// CONFIGURATION
// - XFM_REC_CSC_EN defined: inverse YCoCg-R as above (R/G/B output).
// - XFM_REC_CSC_EN undefined: no colour conversion; widths and timing are unchanged.
//   - out_r = Y
//   - out_g = clip(Co + 2^(BPC-1))
//   - out_b = clip(Cg + 2^(BPC-1))
// TESTING
// - All scenarios use BPC = 8, DEPTH = 2, CSC enabled unless noted.
// - 1) Single block, all samples Y=100, Co=0, Cg=0, out_rdy=1.
//   - -> R=G=B=100 in all 8 cols on two beats.
//   - -> out_row 0 then 1; out_last=1 only on the second beat; first beat 2 cycles after accept.
// - 2) Clip check, Y=255, Co=255, Cg=255 -> R=255, G=255, B=1.
//   - Y=0, Co=-256, Cg=-256 -> R=0, G=0, B=255.
// - 3) Backpressure: out_rdy=0, offer 3 blocks with distinct Y (10, 20, 30).
//   - -> blocks 1 and 2 accepted, rec_rdy=0, block 3 held.
//   - -> out_* stable while stalled.
//   - Release out_rdy -> 6 rows in order Y 10,10,20,20,30,30; no loss, no duplication.
// - 4) Streaming: rec_vld=1 every cycle, out_rdy=1.
//   - -> one block accepted every 2 cycles.
//   - -> out_vld continuously high after the initial latency.
//   - -> count never exceeds DEPTH.
// - 5) Reset mid-operation: drop rstn while row 0 is presented and a second block is buffered.
//   - -> out_vld=0 immediately.
//   - -> after reset, a new block Y=50 outputs only Y=50 rows.
// - 6) XFM_REC_CSC_EN undefined, Y=100, Co=-20, Cg=30 -> out_r=100, out_g=108, out_b=158.

Source files
------------

// File: rtl/xfm_rec_pix_out_if.sv
// Handshake/bus bundle between the reconstruction stage, xfm_rec_pix_out and the line store.
// slave = the pixel-out block's view; master = the environment driving it.
interface xfm_rec_pix_out_if #(
    parameter int BPC = 8
);
    logic                    rec_vld;
    logic                    rec_rdy;
    logic [16*BPC-1:0]       rec_c0;
    logic [16*(BPC+1)-1:0]   rec_c1;
    logic [16*(BPC+1)-1:0]   rec_c2;
    logic                    out_vld;
    logic                    out_rdy;
    logic [8*BPC-1:0]        out_r;
    logic [8*BPC-1:0]        out_g;
    logic [8*BPC-1:0]        out_b;
    logic                    out_row;
    logic                    out_last;

    modport slave (
        input  rec_vld, rec_c0, rec_c1, rec_c2, out_rdy,
        output rec_rdy, out_vld, out_r, out_g, out_b, out_row, out_last
    );

    modport master (
        output rec_vld, rec_c0, rec_c1, rec_c2, out_rdy,
        input  rec_rdy, out_vld, out_r, out_g, out_b, out_row, out_last
    );
endinterface

// File: rtl/xfm_rec_pix_out.sv
// Buffers 8x2 reconstructed blocks and emits one clipped 8-pixel row per beat.
// Define XFM_REC_CSC_EN for inverse YCoCg-R; otherwise Y/Co/Cg pass through offset and clipped.
module xfm_rec_pix_out #(
    parameter int BPC   = 8,
    parameter int DEPTH = 2
) (
    input logic               clk,
    input logic               rstn,
    xfm_rec_pix_out_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic signed [BPC+2:0] C_MAX = (BPC+3)'((1 << BPC) - 1);
`ifndef XFM_REC_CSC_EN
    localparam logic signed [BPC+2:0] C_HALF = (BPC+3)'(1 << (BPC - 1));
`endif

    function automatic logic [BPC-1:0] clip(input logic signed [BPC+2:0] v);
        if (v[BPC+2])
            return '0;
        else if (v > C_MAX)
            return '1;
        else
            return v[BPC-1:0];
    endfunction

    // Returns {R, G, B} (or {Y, Co', Cg'} in pass-through builds) for one pixel.
    function automatic logic [3*BPC-1:0] conv(input logic [BPC-1:0]      y,
                                              input logic signed [BPC:0] co,
                                              input logic signed [BPC:0] cg);
        logic signed [BPC+2:0] sco;
        logic signed [BPC+2:0] scg;
`ifdef XFM_REC_CSC_EN
        logic signed [BPC+2:0] sy;
        logic signed [BPC+2:0] t;
        logic signed [BPC+2:0] g;
        logic signed [BPC+2:0] b;
        logic signed [BPC+2:0] r;
`endif
        sco = {{2{co[BPC]}}, co};
        scg = {{2{cg[BPC]}}, cg};
`ifdef XFM_REC_CSC_EN
        sy  = {3'b000, y};
        t   = sy - (scg >>> 1);
        g   = scg + t;
        b   = t - (sco >>> 1);
        r   = b + sco;
        return {clip(r), clip(g), clip(b)};
`else
        return {y, clip(sco + C_HALF), clip(scg + C_HALF)};
`endif
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [16*BPC-1:0]     r_mem_c0 [DEPTH];
    logic [16*(BPC+1)-1:0] r_mem_c1 [DEPTH];
    logic [16*(BPC+1)-1:0] r_mem_c2 [DEPTH];

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_row_sel;
    logic             r_rec_rdy;
    logic             r_out_vld;
    logic [8*BPC-1:0] r_out_r;
    logic [8*BPC-1:0] r_out_g;
    logic [8*BPC-1:0] r_out_b;
    logic             r_out_row;
    logic             r_out_last;

    logic             w_push;
    logic             w_load;
    logic             w_pop;
    logic [CW-1:0]    w_count_nxt;
    logic [8*BPC-1:0]     w_row_c0;
    logic [8*(BPC+1)-1:0] w_row_c1;
    logic [8*(BPC+1)-1:0] w_row_c2;
    logic [8*BPC-1:0] w_pix_r;
    logic [8*BPC-1:0] w_pix_g;
    logic [8*BPC-1:0] w_pix_b;

    // row_sel is the whole FSM: 0 = next load is row 0, 1 = next load is row 1 and pops.
    assign w_push = bus.rec_vld && r_rec_rdy;
    assign w_load = (!r_out_vld || bus.out_rdy) && (r_count != '0);
    assign w_pop  = w_load && r_row_sel;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + CW'(1);
        else if (!w_push && w_pop)
            w_count_nxt = r_count - CW'(1);
    end

    assign w_row_c0 = r_mem_c0[r_rd_ptr][r_row_sel*8*BPC +: 8*BPC];
    assign w_row_c1 = r_mem_c1[r_rd_ptr][r_row_sel*8*(BPC+1) +: 8*(BPC+1)];
    assign w_row_c2 = r_mem_c2[r_rd_ptr][r_row_sel*8*(BPC+1) +: 8*(BPC+1)];

    for (genvar j = 0; j < 8; j++) begin : g_col
        logic [3*BPC-1:0] w_rgb;
        assign w_rgb = conv(w_row_c0[j*BPC +: BPC],
                            w_row_c1[j*(BPC+1) +: BPC+1],
                            w_row_c2[j*(BPC+1) +: BPC+1]);
        assign w_pix_r[j*BPC +: BPC] = w_rgb[2*BPC +: BPC];
        assign w_pix_g[j*BPC +: BPC] = w_rgb[BPC +: BPC];
        assign w_pix_b[j*BPC +: BPC] = w_rgb[0 +: BPC];
    end

    // Block storage carries no reset; validity lives entirely in the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_c0[r_wr_ptr] <= bus.rec_c0;
            r_mem_c1[r_wr_ptr] <= bus.rec_c1;
            r_mem_c2[r_wr_ptr] <= bus.rec_c2;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_row_sel  <= 1'b0;
            r_rec_rdy  <= 1'b0;
            r_out_vld  <= 1'b0;
            r_out_r    <= '0;
            r_out_g    <= '0;
            r_out_b    <= '0;
            r_out_row  <= 1'b0;
            r_out_last <= 1'b0;
        end else begin
            r_count   <= w_count_nxt;
            r_rec_rdy <= (w_count_nxt < CW'(DEPTH));
            if (w_push)
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_load) begin
                r_out_vld  <= 1'b1;
                r_out_r    <= w_pix_r;
                r_out_g    <= w_pix_g;
                r_out_b    <= w_pix_b;
                r_out_row  <= r_row_sel;
                r_out_last <= r_row_sel;
                r_row_sel  <= ~r_row_sel;
            end else if (bus.out_rdy && r_out_vld) begin
                r_out_vld <= 1'b0;
            end
        end
    end

    assign bus.rec_rdy  = r_rec_rdy;
    assign bus.out_vld  = r_out_vld;
    assign bus.out_r    = r_out_r;
    assign bus.out_g    = r_out_g;
    assign bus.out_b    = r_out_b;
    assign bus.out_row  = r_out_row;
    assign bus.out_last = r_out_last;
endmodule

// File: tb/tb_xfm_rec_pix_out.sv
// Self-checking bench for xfm_rec_pix_out (BPC=8, DEPTH=2); follows XFM_REC_CSC_EN like the DUT.
// A queue-based row model is fed from accepted input blocks and drained by output beats.
module tb_xfm_rec_pix_out;
    localparam int BPC   = 8;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    xfm_rec_pix_out_if #(.BPC(BPC)) bus ();
    xfm_rec_pix_out #(.BPC(BPC), .DEPTH(DEPTH)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    typedef struct packed {
        logic [63:0] r;
        logic [63:0] g;
        logic [63:0] b;
        logic        row;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int n_beats = 0;

    logic [127:0] b_c0;
    logic [143:0] b_c1;
    logic [143:0] b_c2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int clip8(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    // Pixel reference from the colour rules, in plain integer arithmetic.
    function automatic logic [23:0] ref_pix(input int y, input int co, input int cg);
        int r, g, b;
`ifdef XFM_REC_CSC_EN
        int t;
        t = y - (cg >>> 1);
        g = cg + t;
        b = t - (co >>> 1);
        r = b + co;
`else
        r = y;
        g = co + 128;
        b = cg + 128;
`endif
        r = clip8(r);
        g = clip8(g);
        b = clip8(b);
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    always @(negedge rstn) exp_q.delete();

    always @(negedge clk) begin
        if (rstn) begin
            if (bus.out_vld && bus.out_rdy) begin
                n_beats++;
                if (exp_q.size() == 0) begin
                    chk("spurious_beat", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_r", bus.out_r, e.r);
                    chk("out_g", bus.out_g, e.g);
                    chk("out_b", bus.out_b, e.b);
                    chk("out_row", 64'(bus.out_row), 64'(e.row));
                    chk("out_last", 64'(bus.out_last), 64'(e.row));
                end
            end
            if (bus.rec_vld && bus.rec_rdy) begin
                for (int row = 0; row < 2; row++) begin
                    exp_t e;
                    logic [23:0] px;
                    e.row = (row == 1);
                    for (int j = 0; j < 8; j++) begin
                        int i;
                        i  = row * 8 + j;
                        px = ref_pix(int'(bus.rec_c0[i*8 +: 8]),
                                     int'($signed(bus.rec_c1[i*9 +: 9])),
                                     int'($signed(bus.rec_c2[i*9 +: 9])));
                        e.r[j*8 +: 8] = px[23:16];
                        e.g[j*8 +: 8] = px[15:8];
                        e.b[j*8 +: 8] = px[7:0];
                    end
                    exp_q.push_back(e);
                end
            end
        end
    end

    task automatic set_uni(input int y, input int co, input int cg);
        logic [8:0] c1v, c2v;
        c1v = 9'(co);
        c2v = 9'(cg);
        for (int i = 0; i < 16; i++) begin
            b_c0[i*8 +: 8] = 8'(y);
            b_c1[i*9 +: 9] = c1v;
            b_c2[i*9 +: 9] = c2v;
        end
    endtask

    task automatic set_rand();
        for (int i = 0; i < 16; i++) begin
            b_c0[i*8 +: 8] = 8'($urandom_range(0, 255));
            b_c1[i*9 +: 9] = 9'($urandom_range(0, 511));
            b_c2[i*9 +: 9] = 9'($urandom_range(0, 511));
        end
    endtask

    // Offers b_c* until accepted; returns #1 after the accepting edge with rec_vld low.
    task automatic send(input string tag);
        int n;
        bit ok;
        n  = 0;
        ok = 0;
        bus.rec_c0  = b_c0;
        bus.rec_c1  = b_c1;
        bus.rec_c2  = b_c2;
        bus.rec_vld = 1'b1;
        while (!ok && n < 60) begin
            @(negedge clk);
            if (bus.rec_rdy) ok = 1;
            else n++;
        end
        if (!ok) chk({tag, "_accept_timeout"}, 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.rec_vld = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_vld) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] snap_r, snap_g, snap_b;
        int acc, beats0;
        bit acc_now;
        bus.rec_vld = 1'b0;
        bus.rec_c0  = '0;
        bus.rec_c1  = '0;
        bus.rec_c2  = '0;
        bus.out_rdy = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rec_rdy", 64'(bus.rec_rdy), 64'd0);
        chk("rst_out_vld", 64'(bus.out_vld), 64'd0);
        chk("rst_out_row", 64'(bus.out_row), 64'd0);
        chk("rst_out_last", 64'(bus.out_last), 64'd0);
        chk("rst_out_r", bus.out_r, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("rdy_after_rst", 64'(bus.rec_rdy), 64'd1);

        // Single block, latency and row markers
        bus.out_rdy = 1'b1;
        set_uni(100, 0, 0);
        send("single");
        chk("lat_not_yet", 64'(bus.out_vld), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_row0_vld", 64'(bus.out_vld), 64'd1);
        chk("lat_row0_row", 64'(bus.out_row), 64'd0);
        chk("lat_row0_last", 64'(bus.out_last), 64'd0);
`ifdef XFM_REC_CSC_EN
        chk("single_r", bus.out_r, {8{8'd100}});
        chk("single_g", bus.out_g, {8{8'd100}});
        chk("single_b", bus.out_b, {8{8'd100}});
`endif
        @(posedge clk);
        #1;
        chk("lat_row1_vld", 64'(bus.out_vld), 64'd1);
        chk("lat_row1_row", 64'(bus.out_row), 64'd1);
        chk("lat_row1_last", 64'(bus.out_last), 64'd1);
        @(posedge clk);
        #1;
        chk("lat_idle", 64'(bus.out_vld), 64'd0);

        // Clip boundaries
        set_uni(255, 255, 255);
        send("clip_hi");
        @(posedge clk);
        #1;
`ifdef XFM_REC_CSC_EN
        chk("clip_hi_r", 64'(bus.out_r[7:0]), 64'd255);
        chk("clip_hi_g", 64'(bus.out_g[7:0]), 64'd255);
        chk("clip_hi_b", 64'(bus.out_b[7:0]), 64'd1);
`endif
        drain("clip_hi");
        set_uni(0, -256, -256);
        send("clip_lo");
        @(posedge clk);
        #1;
`ifdef XFM_REC_CSC_EN
        chk("clip_lo_r", 64'(bus.out_r[7:0]), 64'd0);
        chk("clip_lo_g", 64'(bus.out_g[7:0]), 64'd0);
        chk("clip_lo_b", 64'(bus.out_b[7:0]), 64'd255);
`endif
        drain("clip_lo");

`ifndef XFM_REC_CSC_EN
        set_uni(100, -20, 30);
        send("bypass");
        @(posedge clk);
        #1;
        chk("bypass_r", 64'(bus.out_r[7:0]), 64'd100);
        chk("bypass_g", 64'(bus.out_g[7:0]), 64'd108);
        chk("bypass_b", 64'(bus.out_b[7:0]), 64'd158);
        drain("bypass");
`endif

        // Backpressure: two blocks fit, the third is held
        bus.out_rdy = 1'b0;
        beats0 = n_beats;
        set_uni(10, 0, 0);
        send("bp1");
        set_uni(20, 0, 0);
        send("bp2");
        chk("bp_full_rdy", 64'(bus.rec_rdy), 64'd0);
        set_uni(30, 0, 0);
        bus.rec_c0  = b_c0;
        bus.rec_c1  = b_c1;
        bus.rec_c2  = b_c2;
        bus.rec_vld = 1'b1;
        @(negedge clk);
        snap_r = bus.out_r;
        snap_g = bus.out_g;
        snap_b = bus.out_b;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_hold_rdy", 64'(bus.rec_rdy), 64'd0);
            chk("bp_hold_vld", 64'(bus.out_vld), 64'd1);
            chk("bp_hold_r", bus.out_r, snap_r);
            chk("bp_hold_g", bus.out_g, snap_g);
            chk("bp_hold_b", bus.out_b, snap_b);
        end
        @(posedge clk);
        #1;
        bus.out_rdy = 1'b1;
        send("bp3");
        drain("bp");
        chk("bp_beats", 64'(n_beats - beats0), 64'd6);

        // Streaming: one block every two cycles, out_vld unbroken
        acc = 0;
        set_rand();
        bus.rec_c0  = b_c0;
        bus.rec_c1  = b_c1;
        bus.rec_c2  = b_c2;
        bus.rec_vld = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            #1;
            if (cyc >= 4) chk("stream_vld", 64'(bus.out_vld), 64'd1);
            chk("stream_occ", 64'(exp_q.size() <= 2 * DEPTH), 64'd1);
            acc_now = bus.rec_vld && bus.rec_rdy;
            if (cyc >= 10 && cyc < 30 && acc_now) acc++;
            @(posedge clk);
            #1;
            if (acc_now) begin
                set_rand();
                bus.rec_c0 = b_c0;
                bus.rec_c1 = b_c1;
                bus.rec_c2 = b_c2;
            end
        end
        bus.rec_vld = 1'b0;
        chk("stream_rate", 64'(acc), 64'd10);
        drain("stream");

        // Random traffic with random backpressure
        begin
            bit done;
            done = 0;
            fork
                begin
                    for (int k = 0; k < 30; k++) begin
                        set_rand();
                        send("rand");
                    end
                    done = 1;
                end
                begin
                    while (!done) begin
                        @(posedge clk);
                        #1;
                        bus.out_rdy = ($urandom_range(0, 1) == 1);
                    end
                end
            join
        end
        bus.out_rdy = 1'b1;
        drain("rand");

        // Reset with row 0 presented and a second block buffered
        bus.out_rdy = 1'b0;
        set_uni(70, 0, 0);
        send("pre_rst1");
        set_uni(80, 0, 0);
        send("pre_rst2");
        chk("pre_rst_vld", 64'(bus.out_vld), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_vld", 64'(bus.out_vld), 64'd0);
        chk("mid_rst_rdy", 64'(bus.rec_rdy), 64'd0);
        chk("mid_rst_r", bus.out_r, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        bus.out_rdy = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_rdy", 64'(bus.rec_rdy), 64'd1);
        beats0 = n_beats;
        set_uni(50, 0, 0);
        send("post_rst");
        @(posedge clk);
        #1;
        chk("post_rst_r", bus.out_r, {8{8'd50}});
        drain("post_rst");
        chk("post_rst_beats", 64'(n_beats - beats0), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
